// File: rtl/spi_fb_writer_if.sv
// Pixel stream in / BRAM write port out for spi_fb_writer.
// slave is the sequencer side, master is the stream source / BRAM side.
interface spi_fb_writer_if #(
  parameter int unsigned H_COUNT    = 10,
  parameter int unsigned V_COUNT    = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned AW = $clog2(H_COUNT * V_COUNT);
  localparam int unsigned HW = $clog2(H_COUNT);
  localparam int unsigned VW = $clog2(V_COUNT);

  logic                  frame_start_in;
  logic                  data_valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we_out;
  logic [AW-1:0]         addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [HW-1:0]         hcount_out;
  logic [VW-1:0]         vcount_out;
  logic                  frame_done_out;
  logic                  frame_err_out;

  modport master (
    output frame_start_in, data_valid_in, data_in,
    input  we_out, addr_out, data_out, hcount_out, vcount_out, frame_done_out, frame_err_out
  );

  modport slave (
    input  frame_start_in, data_valid_in, data_in,
    output we_out, addr_out, data_out, hcount_out, vcount_out, frame_done_out, frame_err_out
  );
endinterface

// File: rtl/spi_fb_writer.sv
// Receive-side frame-buffer write sequencer: raster-tracks SPI pixel bytes into BRAM writes.
// Optional macro SPI_FB_FRAME_ERR_EN builds the sticky framing-error detector.
module spi_fb_writer #(
  parameter int unsigned H_COUNT    = 10,
  parameter int unsigned V_COUNT    = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           clk_in,
  input logic           rst_in,
  spi_fb_writer_if.slave bus
);
  localparam int unsigned AW = $clog2(H_COUNT * V_COUNT);
  localparam int unsigned HW = $clog2(H_COUNT);
  localparam int unsigned VW = $clog2(V_COUNT);
  localparam logic [HW-1:0] HMax = HW'(H_COUNT - 1);
  localparam logic [VW-1:0] VMax = VW'(V_COUNT - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d, cur_h;
  logic [VW-1:0]   v_q, v_d, cur_v;
  logic            accept, last;

  logic                  s0_valid_q, s0_last_q;
  logic [HW-1:0]         s0_h_q;
  logic [VW-1:0]         s0_v_q;
  logic [DATA_WIDTH-1:0] s0_data_q;

  logic                  we_q, done_q;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [HW-1:0]         hcount_q;
  logic [VW-1:0]         vcount_q;

  // frame_start overrides the old position so a coincident byte lands at (0,0).
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    cur_h   = bus.frame_start_in ? '0 : h_q;
    cur_v   = bus.frame_start_in ? '0 : v_q;
    accept  = bus.data_valid_in && (bus.frame_start_in || (state_q == StRecv));
    last    = (cur_h == HMax) && (cur_v == VMax);
    if (bus.frame_start_in) begin
      state_d = StRecv;
      h_d     = '0;
      v_d     = '0;
    end
    if (accept) begin
      if (last) begin
        state_d = StIdle;
        h_d     = '0;
        v_d     = '0;
      end else if (cur_h == HMax) begin
        h_d = '0;
        v_d = cur_v + VW'(1);
      end else begin
        h_d = cur_h + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Stage 0: capture position and pixel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_h_q     <= '0;
      s0_v_q     <= '0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= accept;
      s0_last_q  <= accept && last;
      if (accept) begin
        s0_h_q    <= cur_h;
        s0_v_q    <= cur_v;
        s0_data_q <= bus.data_in;
      end
    end
  end

  always_comb addr_d = AW'(s0_v_q) * AW'(H_COUNT) + AW'(s0_h_q);

  // Stage 1: BRAM write port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      we_q   <= s0_valid_q;
      done_q <= s0_valid_q && s0_last_q;
      if (s0_valid_q) begin
        addr_q   <= addr_d;
        data_q   <= s0_data_q;
        hcount_q <= s0_h_q;
        vcount_q <= s0_v_q;
      end
    end
  end

  assign bus.we_out         = we_q;
  assign bus.addr_out       = addr_q;
  assign bus.data_out       = data_q;
  assign bus.hcount_out     = hcount_q;
  assign bus.vcount_out     = vcount_q;
  assign bus.frame_done_out = done_q;

`ifdef SPI_FB_FRAME_ERR_EN
  logic err_q, err_d;

  // Short frame: restart after at least one pixel. Overrun: byte while idle.
  always_comb begin
    err_d = err_q;
    if (bus.frame_start_in && (state_q == StRecv) && ((h_q != '0) || (v_q != '0))) begin
      err_d = 1'b1;
    end
    if (bus.data_valid_in && !bus.frame_start_in && (state_q == StIdle)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.frame_err_out = err_q;
`else
  assign bus.frame_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_spi_fb_writer.sv
// Directed bench for spi_fb_writer: 10x8 instance for frame tests, 12x5 instance for wrap.
module tb_spi_fb_writer;
`ifdef SPI_FB_FRAME_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  spi_fb_writer_if #(.H_COUNT(10), .V_COUNT(8), .DATA_WIDTH(8)) bus_a ();
  spi_fb_writer_if #(.H_COUNT(12), .V_COUNT(5), .DATA_WIDTH(8)) bus_b ();

  spi_fb_writer #(.H_COUNT(10), .V_COUNT(8), .DATA_WIDTH(8)) u_dut_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_a)
  );

  spi_fb_writer #(.H_COUNT(12), .V_COUNT(5), .DATA_WIDTH(8)) u_dut_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_b)
  );

  typedef struct {
    int addr;
    int data;
    int h;
    int v;
    int done;
    int cyc;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  done_a = 0, done_b = 0, consec_a = 0;
  bit  prev_we_a = 1'b0;

  always @(negedge clk_in) begin
    if (bus_a.we_out === 1'b1) begin
      qa.push_back('{int'(bus_a.addr_out), int'(bus_a.data_out), int'(bus_a.hcount_out),
                     int'(bus_a.vcount_out), int'(bus_a.frame_done_out), cyc});
      if (prev_we_a) consec_a++;
    end
    prev_we_a = (bus_a.we_out === 1'b1);
    if (bus_a.frame_done_out === 1'b1) done_a++;
    if (bus_b.we_out === 1'b1) begin
      qb.push_back('{int'(bus_b.addr_out), int'(bus_b.data_out), int'(bus_b.hcount_out),
                     int'(bus_b.vcount_out), int'(bus_b.frame_done_out), cyc});
    end
    if (bus_b.frame_done_out === 1'b1) done_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_a(input logic fs, input logic dv, input logic [7:0] d);
    bus_a.frame_start_in = fs;
    bus_a.data_valid_in  = dv;
    bus_a.data_in        = d;
    step();
  endtask

  task automatic send_b(input logic fs, input logic dv, input logic [7:0] d);
    bus_b.frame_start_in = fs;
    bus_b.data_valid_in  = dv;
    bus_b.data_in        = d;
    step();
  endtask

  task automatic idle(input int n);
    bus_a.frame_start_in = 1'b0;
    bus_a.data_valid_in  = 1'b0;
    bus_b.frame_start_in = 1'b0;
    bus_b.data_valid_in  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear();
    qa.delete();
    qb.delete();
    done_a   = 0;
    done_b   = 0;
    consec_a = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
    idle(1);
    clear();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " we"},    32'(bus_a.we_out),         0);
    check({pfx, " addr"},  32'(bus_a.addr_out),       0);
    check({pfx, " data"},  32'(bus_a.data_out),       0);
    check({pfx, " h"},     32'(bus_a.hcount_out),     0);
    check({pfx, " v"},     32'(bus_a.vcount_out),     0);
    check({pfx, " done"},  32'(bus_a.frame_done_out), 0);
    check({pfx, " err"},   32'(bus_a.frame_err_out),  0);
  endtask

  // Expect records 0..n-1 of qa to be pixel i with data i in a 10-wide raster.
  task automatic check_frame_a(input string pfx, input int n);
    check({pfx, " writes"}, qa.size(), n);
    for (int i = 0; i < n && i < qa.size(); i++) begin
      check($sformatf("%s addr[%0d]", pfx, i), qa[i].addr, i);
      check($sformatf("%s data[%0d]", pfx, i), qa[i].data, i);
      check($sformatf("%s h[%0d]", pfx, i),    qa[i].h,    i % 10);
      check($sformatf("%s v[%0d]", pfx, i),    qa[i].v,    i / 10);
      check($sformatf("%s done[%0d]", pfx, i), qa[i].done, (i == 79) ? 1 : 0);
    end
  endtask

  int fc;

  initial begin
    bus_a.frame_start_in = 1'b0;
    bus_a.data_valid_in  = 1'b0;
    bus_a.data_in        = '0;
    bus_b.frame_start_in = 1'b0;
    bus_b.data_valid_in  = 1'b0;
    bus_b.data_in        = '0;

    // Reset state.
    idle(3);
    check_reset_outputs("reset");
    rst_in = 1'b0;
    idle(1);
    clear();

    // Full frame, back-to-back bytes.
    send_a(1'b1, 1'b0, 8'h00);
    fc = cyc;
    for (int i = 0; i < 80; i++) send_a(1'b0, 1'b1, 8'(i));
    idle(5);
    check_frame_a("full", 80);
    if (qa.size() > 0) check("full latency", qa[0].cyc, fc + 2);
    check("full done count", done_a, 1);
    check("full err", 32'(bus_a.frame_err_out), 0);

    // Gapped stream, valid every third cycle.
    do_reset();
    send_a(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 80; i++) begin
      send_a(1'b0, 1'b1, 8'(i));
      idle(2);
    end
    idle(4);
    check_frame_a("gap", 80);
    check("gap back-to-back we", consec_a, 0);
    check("gap done count", done_a, 1);

    // Short frame restarted by frame_start + valid.
    do_reset();
    send_a(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 25; i++) send_a(1'b0, 1'b1, 8'(i));
    send_a(1'b1, 1'b1, 8'hAA);
    idle(5);
    check("short writes", qa.size(), 26);
    for (int i = 0; i < 25 && i < qa.size(); i++) begin
      check($sformatf("short addr[%0d]", i), qa[i].addr, i);
      check($sformatf("short data[%0d]", i), qa[i].data, i);
    end
    if (qa.size() > 25) begin
      check("short new addr", qa[25].addr, 0);
      check("short new data", qa[25].data, 32'hAA);
      check("short new h", qa[25].h, 0);
      check("short new v", qa[25].v, 0);
    end
    check("short done count", done_a, 0);
    check("short err", 32'(bus_a.frame_err_out), 32'(ErrEn));

    // Bytes before any frame_start are dropped.
    do_reset();
    for (int i = 0; i < 3; i++) send_a(1'b0, 1'b1, 8'(8'h30 + i));
    idle(5);
    check("idle drop writes", qa.size(), 0);
    check("idle drop err", 32'(bus_a.frame_err_out), 32'(ErrEn));

    // Bytes after the last pixel are dropped.
    do_reset();
    send_a(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 82; i++) send_a(1'b0, 1'b1, 8'(i));
    idle(5);
    check_frame_a("overrun", 80);
    check("overrun done count", done_a, 1);
    check("overrun err", 32'(bus_a.frame_err_out), 32'(ErrEn));

    // Reset one cycle after byte 40: byte 40 is still in stage 0 and is lost.
    do_reset();
    send_a(1'b1, 1'b0, 8'h00);
    for (int i = 0; i <= 40; i++) send_a(1'b0, 1'b1, 8'(i));
    bus_a.data_valid_in = 1'b0;
    rst_in = 1'b1;
    idle(2);
    check("rst mid writes before", qa.size(), 40);
    clear();
    rst_in = 1'b0;
    idle(5);
    check("rst mid writes after", qa.size(), 0);
    check_reset_outputs("rst mid");
    send_a(1'b1, 1'b1, 8'h55);
    idle(4);
    check("rst restart writes", qa.size(), 1);
    if (qa.size() > 0) begin
      check("rst restart addr", qa[0].addr, 0);
      check("rst restart data", qa[0].data, 32'h55);
    end

    // Row wrap on a 12x5 raster.
    do_reset();
    send_b(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++) send_b(1'b0, 1'b1, 8'(i));
    idle(5);
    check("wrap writes", qb.size(), 60);
    if (qb.size() == 60) begin
      check("wrap addr[11]", qb[11].addr, 11);
      check("wrap h[11]",    qb[11].h,    11);
      check("wrap v[11]",    qb[11].v,    0);
      check("wrap addr[12]", qb[12].addr, 12);
      check("wrap h[12]",    qb[12].h,    0);
      check("wrap v[12]",    qb[12].v,    1);
      check("wrap addr[59]", qb[59].addr, 59);
      check("wrap h[59]",    qb[59].h,    11);
      check("wrap v[59]",    qb[59].v,    4);
      check("wrap done[59]", qb[59].done, 1);
      check("wrap data[37]", qb[37].data, 37);
    end
    check("wrap done count", done_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
